// File: rtl/trace_stream_ctrl.sv
// -----------------------------------------------------------------------------
// trace_stream_ctrl
//
// Packs 64-bit trace records from the role's trace source into 512-bit beats
// (eight records per beat, record k in lane k), buffers the beats in a small
// first-word-fall-through FIFO and drives them out on the m_axis_trace
// AXI4-Stream port. Beats are grouped into packets of PKT_BEATS beats with
// tlast on the final beat. An open packet is closed early, with a partial
// (or null) beat carrying tlast, on an idle timeout or on a software flush.
// When the output stalls the source is either backpressured (LOSSY=0) or
// the blocked records are counted and discarded (LOSSY=1).
//
// Ports
//   aclk, aresetn           clock, asynchronous active-low reset
//   trace_valid/ready/data  record input handshake (64-bit records)
//   cfg_enable              level; 0 stops accepting new records
//   cfg_flush               one-cycle pulse: close open packet, then drain
//   cfg_timeout             idle cycles before a forced close (0 = off)
//   flush_done              one-cycle pulse once a flush has drained
//   busy                    staging, FIFO or close/drain sequence active
//   drop_cnt                saturating count of discarded records (LOSSY=1)
//   m_axis_trace_*          AXI4-Stream master (512-bit data, 64-bit keep)
// -----------------------------------------------------------------------------
module trace_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PKT_BEATS  = 4,
  parameter bit LOSSY      = 1'b0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         trace_valid,
  output logic         trace_ready,
  input  logic [63:0]  trace_data,
  input  logic         cfg_enable,
  input  logic         cfg_flush,
  input  logic [15:0]  cfg_timeout,
  output logic         flush_done,
  output logic         busy,
  output logic [31:0]  drop_cnt,
  output logic         m_axis_trace_tvalid,
  input  logic         m_axis_trace_tready,
  output logic [511:0] m_axis_trace_tdata,
  output logic [63:0]  m_axis_trace_tkeep,
  output logic         m_axis_trace_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [PW-1:0] PKT_LAST_IDX = PW'(PKT_BEATS - 1);
  localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CLOSE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                flush_flag_q, flush_flag_d;
  logic [2:0]          slot_cnt_q, slot_cnt_d;
  logic [PW-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         idle_cnt_q, idle_cnt_d;
  logic [31:0]         drop_cnt_q, drop_cnt_d;
  logic                flush_done_q, flush_done_d;
  logic [7:0][63:0]    stage_q, stage_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  // Beat storage: data, byte keep and tlast per entry
  logic [511:0]        mem_data [FIFO_DEPTH];
  logic [63:0]         mem_keep [FIFO_DEPTH];
  logic                mem_last [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                fifo_full;
  logic                fifo_empty;
  logic                pkt_open;
  logic                slot_last;
  logic                pkt_last;
  logic                blocked;
  logic                take;
  logic                drop;
  logic                pop;
  logic                push;
  logic [511:0]        push_data;
  logic [63:0]         push_keep;
  logic                push_last;
  logic [511:0]        full_beat;
  logic [511:0]        close_beat;
  logic [63:0]         close_keep;
  logic [16:0]         idle_inc;
  logic                timeout_hit;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pkt_open   = (pkt_cnt_q != '0) || (slot_cnt_q != 3'd0);
  assign slot_last  = (slot_cnt_q == 3'd7);
  assign pkt_last   = (pkt_cnt_q == PKT_LAST_IDX);

  // The 8th record of a beat needs a FIFO slot in the same cycle.
  assign blocked = slot_last & fifo_full;

  assign trace_ready = cfg_enable & (state_q == ST_RUN) & (LOSSY | ~blocked);
  assign take        = trace_valid & trace_ready & ~blocked;
  // Only reachable in lossy mode: ready stays high while the beat is blocked.
  assign drop        = trace_valid & trace_ready & blocked;

  assign pop = m_axis_trace_tvalid & m_axis_trace_tready;

  assign idle_inc    = {1'b0, idle_cnt_q} + 17'd1;
  // The idle count is about to reach the programmed limit this cycle.
  assign timeout_hit = pkt_open & ~take & (cfg_timeout != 16'd0) &
                       (idle_inc == {1'b0, cfg_timeout});

  // ---------------------------------------------------------------------------
  // Per-lane staging and beat assembly
  //   full_beat : staging with the incoming record placed in the current slot
  //   close_beat: only the lanes already filled; unused lanes forced to zero
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [2:0] LANE = 3'(gi);
      assign full_beat[64*gi +: 64]  = (slot_cnt_q == LANE) ? trace_data : stage_q[gi];
      assign close_beat[64*gi +: 64] = (LANE < slot_cnt_q) ? stage_q[gi] : 64'd0;
      assign close_keep[8*gi +: 8]   = (LANE < slot_cnt_q) ? 8'hFF : 8'h00;
      assign stage_d[gi]             = (take && (slot_cnt_q == LANE)) ? trace_data
                                                                      : stage_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control: packing, framing, idle timer, drop counter and FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    flush_flag_d = flush_flag_q;
    slot_cnt_d   = slot_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    flush_done_d = 1'b0;
    push         = 1'b0;
    push_data    = full_beat;
    push_keep    = '1;
    push_last    = 1'b0;

    // Record acceptance (only possible in RUN because trace_ready needs RUN)
    if (take) begin
      if (slot_last) begin
        push       = 1'b1;
        push_last  = pkt_last;
        slot_cnt_d = 3'd0;
        pkt_cnt_d  = pkt_last ? '0 : pkt_cnt_q + PW'(1);
      end else begin
        slot_cnt_d = slot_cnt_q + 3'd1;
      end
    end

    if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (take) begin
          idle_cnt_d = 16'd0;
        end else if (pkt_open && (idle_cnt_q != 16'hFFFF)) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
        // Flush outranks a coincident timeout so the drain still happens.
        if (cfg_flush) begin
          state_d      = ST_CLOSE;
          flush_flag_d = 1'b1;
          idle_cnt_d   = 16'd0;
        end else if (timeout_hit) begin
          state_d      = ST_CLOSE;
          flush_flag_d = 1'b0;
          idle_cnt_d   = 16'd0;
        end
      end

      ST_CLOSE: begin
        idle_cnt_d = 16'd0;
        if (!pkt_open) begin
          state_d = flush_flag_q ? ST_DRAIN : ST_RUN;
        end else if (!fifo_full) begin
          // Partial beat, or a null beat (keep=0) when staging is empty
          push       = 1'b1;
          push_data  = close_beat;
          push_keep  = close_keep;
          push_last  = 1'b1;
          slot_cnt_d = 3'd0;
          pkt_cnt_d  = '0;
          state_d    = flush_flag_q ? ST_DRAIN : ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (fifo_empty) begin
          flush_done_d = 1'b1;
          flush_flag_d = 1'b0;
          state_d      = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer bookkeeping; push and pop together keep the count unchanged,
  // which also covers a push into a full FIFO that is popping.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_RUN;
      flush_flag_q <= 1'b0;
      slot_cnt_q   <= 3'd0;
      pkt_cnt_q    <= '0;
      idle_cnt_q   <= 16'd0;
      drop_cnt_q   <= 32'd0;
      flush_done_q <= 1'b0;
      stage_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_flag_q <= flush_flag_d;
      slot_cnt_q   <= slot_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      flush_done_q <= flush_done_d;
      stage_q      <= stage_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= push_data;
      mem_keep[wr_ptr_q] <= push_keep;
      mem_last[wr_ptr_q] <= push_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry is presented directly (fall-through) and stays put
  // until it is popped. Payload is forced to zero while the FIFO is empty.
  // ---------------------------------------------------------------------------
  assign m_axis_trace_tvalid = ~fifo_empty;
  assign m_axis_trace_tdata  = fifo_empty ? 512'd0 : mem_data[rd_ptr_q];
  assign m_axis_trace_tkeep  = fifo_empty ? 64'd0  : mem_keep[rd_ptr_q];
  assign m_axis_trace_tlast  = fifo_empty ? 1'b0   : mem_last[rd_ptr_q];

  assign flush_done = flush_done_q;
  assign drop_cnt   = drop_cnt_q;
  assign busy       = (slot_cnt_q != 3'd0) | ~fifo_empty | (state_q != ST_RUN);

endmodule
